// File: rtl/x2050_pkg.sv
// x2050_pkg
// Shared definitions for the ROAR sequencer: address/word widths, the
// bit positions of the NA/AB/BB microword fields, and the sequencer
// state encoding.
package x2050_pkg;

  localparam int ROS_AW = 12;   // ROS address width
  localparam int ROS_DW = 90;   // ROS word width

  // Microword field positions
  localparam int NA_HI = 89;
  localparam int NA_LO = 78;
  localparam int AB_HI = 77;
  localparam int AB_LO = 74;
  localparam int BB_HI = 73;
  localparam int BB_LO = 70;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

endpackage

// File: rtl/x2050_nxtaddr.sv
// x2050_nxtaddr
// Combinational next-address formation. The upper ten bits come straight
// from NA; each of the two low bits is either the matching NA bit (select
// code 0) or the condition bit chosen by the select code.
// Ports:
//   na        12-bit next-address field
//   ab, bb    4-bit branch select codes for address bits 1 and 0
//   cond      16-bit condition vector (bit 0 is never selected)
//   next_addr 12-bit next ROS address
module x2050_nxtaddr
  import x2050_pkg::*;
(
  input  logic [ROS_AW-1:0] na,
  input  logic [3:0]        ab,
  input  logic [3:0]        bb,
  input  logic [15:0]       cond,
  output logic [ROS_AW-1:0] next_addr
);

  logic bit_a;
  logic bit_b;

  always_comb begin
    bit_a = (ab == 4'd0) ? na[1] : cond[ab];
    bit_b = (bb == 4'd0) ? na[0] : cond[bb];
    next_addr = {na[ROS_AW-1:2], bit_a, bit_b};
  end

endmodule

// File: rtl/x2050_roar.sv
// x2050_roar
// ROS address register (ROAR) and data register (ROSDR) sequencer.
// ROAR addresses readonly storage; the returned word is latched into
// ROSDR on a latch edge while ROAR advances to the word's next address.
// Optional build macro: X2050_ROS_PARITY_EN adds odd-parity checking of
// each latched word with a sticky error flag.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_ros_data / o_ros_addr ROS read data (same cycle) / address (ROAR)
//   i_start, i_start_addr   load ROAR and enter RUN
//   i_stop, i_step, i_hold  stop, single-step, stall controls
//   i_cond                  branch condition vector
//   i_trap, i_trap_addr     forced branch
//   o_word, o_word_valid    ROSDR and new-word pulse
//   o_run                   high in RUN or STEP
//   o_ros_check             sticky ROS parity error
module x2050_roar
  import x2050_pkg::*;
#(
  parameter logic [11:0] RESET_ADDR = 12'h000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ROS_DW-1:0] i_ros_data,
  output logic [ROS_AW-1:0] o_ros_addr,
  input  logic              i_start,
  input  logic [ROS_AW-1:0] i_start_addr,
  input  logic              i_stop,
  input  logic              i_step,
  input  logic              i_hold,
  input  logic [15:0]       i_cond,
  input  logic              i_trap,
  input  logic [ROS_AW-1:0] i_trap_addr,
  output logic [ROS_DW-1:0] o_word,
  output logic              o_word_valid,
  output logic              o_run,
  output logic              o_ros_check
);

  state_e            state;
  state_e            state_nxt;
  logic              latch;
  logic              load_start;
  logic              load_trap;
  logic              par_bad;
  logic [ROS_AW-1:0] roar;
  logic [ROS_DW-1:0] rosdr;
  logic              word_vld;
  logic [ROS_AW-1:0] next_addr;

  x2050_nxtaddr u_nxtaddr (
    .na        (i_ros_data[NA_HI:NA_LO]),
    .ab        (i_ros_data[AB_HI:AB_LO]),
    .bb        (i_ros_data[BB_HI:BB_LO]),
    .cond      (i_cond),
    .next_addr (next_addr)
  );

`ifdef X2050_ROS_PARITY_EN
  // Good words carry odd parity over all 90 bits.
  assign par_bad = ~(^i_ros_data);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_STOP;
    else          state <= state_nxt;
  end

  // Edge priority: trap, stop, start, hold, normal advance.
  always_comb begin
    state_nxt  = state;
    latch      = 1'b0;
    load_start = 1'b0;
    load_trap  = 1'b0;
    if (i_trap && state != ST_STOP) begin
      load_trap = 1'b1;
      state_nxt = ST_RUN;
    end else if (i_stop && state != ST_STOP) begin
      state_nxt = ST_STOP;
    end else if (i_start) begin
      load_start = 1'b1;
      state_nxt  = ST_RUN;
    end else begin
      case (state)
        ST_RUN:  latch = ~i_hold;
        ST_STEP: begin
          latch     = 1'b1;
          state_nxt = ST_STOP;
        end
        ST_STOP: if (i_step) state_nxt = ST_STEP;
        default: state_nxt = ST_STOP;
      endcase
    end
    // A word failing parity is still latched but halts the sequencer.
    if (latch && par_bad) state_nxt = ST_STOP;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      roar     <= RESET_ADDR;
      rosdr    <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (load_trap) begin
        roar <= i_trap_addr;
      end else if (load_start) begin
        roar <= i_start_addr;
      end else if (latch) begin
        rosdr    <= i_ros_data;
        roar     <= next_addr;
        word_vld <= ~par_bad;
      end
    end
  end

`ifdef X2050_ROS_PARITY_EN
  logic ros_check;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)              ros_check <= 1'b0;
    else if (load_start)       ros_check <= 1'b0;
    else if (latch && par_bad) ros_check <= 1'b1;
  end

  assign o_ros_check = ros_check;
`else
  assign o_ros_check = 1'b0;
`endif

  assign o_ros_addr   = roar;
  assign o_word       = rosdr;
  assign o_word_valid = word_vld;
  assign o_run        = (state != ST_STOP);

endmodule

// File: tb/tb_x2050_roar.sv
// tb_x2050_roar
// Directed bench for the ROAR sequencer. A small ROS image is held in
// the bench and read combinationally at o_ros_addr.
module tb_x2050_roar;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [89:0] i_ros_data;
  logic [11:0] o_ros_addr;
  logic        i_start = 1'b0;
  logic [11:0] i_start_addr = '0;
  logic        i_stop = 1'b0;
  logic        i_step = 1'b0;
  logic        i_hold = 1'b0;
  logic [15:0] i_cond = '0;
  logic        i_trap = 1'b0;
  logic [11:0] i_trap_addr = '0;
  logic [89:0] o_word;
  logic        o_word_valid;
  logic        o_run;
  logic        o_ros_check;

  logic [89:0] rom [0:4095];
  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  assign i_ros_data = rom[o_ros_addr];

  x2050_roar #(.RESET_ADDR(12'h000)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ros_data   (i_ros_data),
    .o_ros_addr   (o_ros_addr),
    .i_start      (i_start),
    .i_start_addr (i_start_addr),
    .i_stop       (i_stop),
    .i_step       (i_step),
    .i_hold       (i_hold),
    .i_cond       (i_cond),
    .i_trap       (i_trap),
    .i_trap_addr  (i_trap_addr),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .o_run        (o_run),
    .o_ros_check  (o_ros_check)
  );

  // Builds a word with the given fields, a tag, and bit 0 set for odd parity.
  function automatic logic [89:0] mk(input logic [11:0] na, input logic [3:0] ab,
                                     input logic [3:0] bb, input logic [7:0] tag);
    logic [89:0] w;
    w        = '0;
    w[89:78] = na;
    w[77:74] = ab;
    w[73:70] = bb;
    w[8:1]   = tag;
    w[0]     = ~(^w[89:1]);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    rom[12'h100] = mk(12'h204, 4'd0, 4'd0, 8'h01);
    rom[12'h204] = mk(12'h3F0, 4'd5, 4'd9, 8'h02);
    rom[12'h3F2] = mk(12'h010, 4'd0, 4'd0, 8'h04);
    rom[12'h3F3] = mk(12'h010, 4'd0, 4'd0, 8'h03);
    rom[12'h010] = mk(12'h011, 4'd0, 4'd0, 8'h10);
    rom[12'h011] = mk(12'h012, 4'd0, 4'd0, 8'h11);
    rom[12'h012] = mk(12'h010, 4'd0, 4'd0, 8'h12);
    rom[12'h0C0] = mk(12'h0C4, 4'd0, 4'd0, 8'h05);
    rom[12'h0C4] = mk(12'h0C8, 4'd0, 4'd0, 8'h06);
    rom[12'h0C8] = mk(12'h0CC, 4'd0, 4'd0, 8'h07);

    // Reset state
    #3 i_reset = 1'b0;
    #1;
    chk("rst_addr",  o_ros_addr, 12'h000);
    chk("rst_word",  o_word, '0);
    chk("rst_valid", o_word_valid, 1'b0);
    chk("rst_run",   o_run, 1'b0);
    chk("rst_check", o_ros_check, 1'b0);
    tick();
    tick();
    i_reset = 1'b1;
    tick();

    // Trap ignored in STOP
    i_trap = 1'b1; i_trap_addr = 12'h0C0;
    tick();
    i_trap = 1'b0;
    chk("trap_stop_addr", o_ros_addr, 12'h000);
    chk("trap_stop_run",  o_run, 1'b0);

    // Start at 100, then advance to 204
    i_start = 1'b1; i_start_addr = 12'h100;
    tick();
    i_start = 1'b0;
    chk("start_addr",  o_ros_addr, 12'h100);
    chk("start_run",   o_run, 1'b1);
    chk("start_valid", o_word_valid, 1'b0);
    i_cond = 16'h0020;
    tick();
    chk("adv_addr",  o_ros_addr, 12'h204);
    chk("adv_word",  o_word, mk(12'h204, 4'd0, 4'd0, 8'h01));
    chk("adv_valid", o_word_valid, 1'b1);

    // Conditional branch: cond bit 5 set, bit 9 clear
    tick();
    chk("br_a_addr", o_ros_addr, 12'h3F2);
    chk("br_a_word", o_word, mk(12'h3F0, 4'd5, 4'd9, 8'h02));

    // Restart at 204 with cond bits 5 and 9 set
    i_start = 1'b1; i_start_addr = 12'h204; i_cond = 16'h0220;
    tick();
    i_start = 1'b0;
    chk("restart_addr", o_ros_addr, 12'h204);
    tick();
    chk("br_ab_addr", o_ros_addr, 12'h3F3);
    chk("br_ab_valid", o_word_valid, 1'b1);

    // Hold for three cycles
    i_cond = '0;
    i_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_addr",  o_ros_addr, 12'h3F3);
      chk("hold_word",  o_word, mk(12'h3F0, 4'd5, 4'd9, 8'h02));
      chk("hold_valid", o_word_valid, 1'b0);
    end
    i_hold = 1'b0;
    tick();
    chk("resume_addr",  o_ros_addr, 12'h010);
    chk("resume_word",  o_word, mk(12'h010, 4'd0, 4'd0, 8'h03));
    chk("resume_valid", o_word_valid, 1'b1);

    // Trap beats stop in RUN
    i_trap = 1'b1; i_trap_addr = 12'h0C0; i_stop = 1'b1;
    tick();
    i_trap = 1'b0; i_stop = 1'b0;
    chk("trap_addr",  o_ros_addr, 12'h0C0);
    chk("trap_run",   o_run, 1'b1);
    chk("trap_valid", o_word_valid, 1'b0);
    chk("trap_word",  o_word, mk(12'h010, 4'd0, 4'd0, 8'h03));
    tick();
    chk("post_trap_addr", o_ros_addr, 12'h0C4);
    chk("post_trap_word", o_word, mk(12'h0C4, 4'd0, 4'd0, 8'h05));

    // Stop, then trap in STOP is ignored
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("stop_addr",  o_ros_addr, 12'h0C4);
    chk("stop_run",   o_run, 1'b0);
    chk("stop_valid", o_word_valid, 1'b0);
    i_trap = 1'b1; i_trap_addr = 12'h0C0;
    tick();
    i_trap = 1'b0;
    chk("stop_trap_addr", o_ros_addr, 12'h0C4);
    chk("stop_trap_run",  o_run, 1'b0);

    // Single step; all-ones cond must not disturb select-code-0 bits
    i_cond = 16'hFFFF;
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    chk("step_run",   o_run, 1'b1);
    chk("step_addr0", o_ros_addr, 12'h0C4);
    chk("step_valid0", o_word_valid, 1'b0);
    tick();
    chk("step_addr",  o_ros_addr, 12'h0C8);
    chk("step_word",  o_word, mk(12'h0C8, 4'd0, 4'd0, 8'h06));
    chk("step_valid", o_word_valid, 1'b1);
    chk("step_run_off", o_run, 1'b0);
    tick();
    chk("step_done_valid", o_word_valid, 1'b0);
    chk("step_done_addr",  o_ros_addr, 12'h0C8);
    i_cond = '0;

    // Asynchronous reset mid-RUN
    i_start = 1'b1; i_start_addr = 12'h010;
    tick();
    i_start = 1'b0;
    tick();
    #2 i_reset = 1'b0;
    #1;
    chk("arst_addr",  o_ros_addr, 12'h000);
    chk("arst_word",  o_word, '0);
    chk("arst_valid", o_word_valid, 1'b0);
    chk("arst_run",   o_run, 1'b0);
    tick();
    i_reset = 1'b1;
    tick();
    chk("arst_hold_addr", o_ros_addr, 12'h000);

`ifdef X2050_ROS_PARITY_EN
    // All-zero word fails odd parity
    i_start = 1'b1; i_start_addr = 12'h300;
    tick();
    i_start = 1'b0;
    tick();
    chk("par_check", o_ros_check, 1'b1);
    chk("par_valid", o_word_valid, 1'b0);
    chk("par_run",   o_run, 1'b0);
    chk("par_word",  o_word, '0);
    tick();
    chk("par_sticky", o_ros_check, 1'b1);
    i_start = 1'b1; i_start_addr = 12'h010;
    tick();
    i_start = 1'b0;
    chk("par_clear", o_ros_check, 1'b0);
    chk("par_restart_run", o_run, 1'b1);
`else
    chk("nopar_check", o_ros_check, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x2050_roar.md
X2050_ROAR -- requirements
Module: x2050_roar

Interface
REQ-001 Parameter RESET_ADDR, default 12'h000: ROAR value loaded on reset.
REQ-002 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset; asserted at 0.
REQ-004 i_ros_data  input  90  word read from readonly storage at o_ros_addr; combinational, same cycle.
REQ-005 o_ros_addr  output  12  ROAR, the current ROS address; driven directly from a register.
REQ-006 i_start  input  1  single-cycle pulse that loads ROAR from i_start_addr and enters RUN.
REQ-007 i_start_addr  input  12  start address.
REQ-008 i_stop  input  1  enter STOP.
REQ-009 i_step  input  1  execute exactly one word from STOP.
REQ-010 i_hold  input  1  stall in RUN.
REQ-011 i_cond  input  16  branch condition vector.
REQ-012 i_trap  input  1  forced branch request.
REQ-013 i_trap_addr  input  12  trap target address.
REQ-014 o_word  output  90  ROSDR, the latched microword.
REQ-015 o_word_valid  output  1  one-cycle pulse per newly latched word.
REQ-016 o_run  output  1  high in RUN or STEP.
REQ-017 o_ros_check  output  1  sticky ROS parity error flag.

Function
REQ-018 Field map: NA = word[89:78], AB = word[77:74], BB = word[73:70].
REQ-019 Next address = {NA[11:2], A, B}.
- A = NA[1] when AB = 0, else i_cond[AB].
- B = NA[0] when BB = 0, else i_cond[BB].
- i_cond[0] is never selected.
REQ-020 States: STOP, RUN, STEP.
REQ-021 On a latch edge, ROSDR <= i_ros_data, ROAR <= next address from i_ros_data, and o_word_valid = 1 on the following cycle.
- Latency: the word at address X appears on o_word one cycle after ROAR = X.
REQ-022 Edge priority, highest first: i_trap, i_stop, i_start, i_hold, normal advance.
REQ-023 i_trap in RUN or STEP: ROAR <= i_trap_addr, ROSDR unchanged, no valid pulse, state -> RUN; i_trap is ignored in STOP.
REQ-024 i_stop in RUN or STEP: ROAR and ROSDR unchanged, no valid pulse, state -> STOP.
REQ-025 i_start in any state: ROAR <= i_start_addr, no latch, state -> RUN, o_ros_check cleared.
REQ-026 i_hold in RUN: ROAR and ROSDR unchanged, no valid pulse; i_hold is ignored in STOP and STEP.
REQ-027 STOP with i_step = 1 -> STEP.
- STEP performs one latch edge, then -> STOP.
- i_step while already in STEP or RUN is ignored.
REQ-028 ROAR wraps modulo 4096; no carry or overflow detection.

Reset
REQ-029 While i_reset = 0, immediately and asynchronously:
- ROAR = RESET_ADDR; o_word = 0; o_word_valid = 0; o_run = 0; o_ros_check = 0; state = STOP.
REQ-030 Reset asserted mid-RUN or mid-STEP aborts the in-flight latch; no partial update is visible.

Configuration
REQ-031 Macro X2050_ROS_PARITY_EN.
- Defined: each latch edge checks odd parity over all 90 bits of i_ros_data.
- On even parity: the word is still latched, o_word_valid is suppressed, o_ros_check is set (sticky until reset or i_start), and state -> STOP.
REQ-032 Macro X2050_ROS_PARITY_EN not defined: o_ros_check is constant 0 and no parity logic is present.

Structure
REQ-033 Package x2050_pkg holds the state enum, the NA/AB/BB bit positions, and the ROS address width (12) and word width (90) constants.
REQ-034 Next-address logic lives in one combinational sub-module, x2050_nxtaddr (inputs: word fields and i_cond; output: 12-bit address); all sequencing stays in x2050_roar.

Verification
REQ-035 Reset then i_start, i_start_addr = 12'h100, ROS[100] has NA = 12'h204, AB = BB = 0 -> o_ros_addr 100, then 204; o_word = ROS[100] with o_word_valid = 1 in the cycle ROAR = 204.
REQ-036 Word NA = 12'h3F0, AB = 5, BB = 9, i_cond = 16'h0020 -> next ROAR = 12'h3F2; with i_cond = 16'h0220 -> 12'h3F3.
REQ-037 RUN with i_hold high for 3 cycles -> ROAR and o_word frozen, o_word_valid = 0 for 3 cycles, then sequencing resumes.
REQ-038 Same-cycle i_trap = 1 (i_trap_addr = 12'h0C0) and i_stop = 1 in RUN -> ROAR = 0C0, state RUN; i_trap in STOP -> no change.
REQ-039 STOP, i_step pulse -> exactly one o_word_valid pulse, o_run high for one cycle, ROAR advanced once, back to STOP.
REQ-040 With X2050_ROS_PARITY_EN defined: a word of all zeros -> o_ros_check = 1, no valid pulse, STOP; a subsequent i_start clears the flag.
